ins_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the instruction register.
- Holds the program counter and runs a request/acknowledge read from instruction memory.
- Drives the fetched byte onto the instruction bus, where the instruction register captures it on its next clock edge.
- The control unit requests each fetch and can redirect the PC for jumps.

---
 rtl/ins_fetch_pkg.sv | 21 ++
 rtl/fetch_timeout_ctr.sv | 51 +++++
 rtl/ins_fetch.sv | 180 ++++++++++++++++++
 tb/tb_ins_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ins_fetch_pkg - shared CPU fetch-path types and default widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ins_fetch_pkg;

  // Shared with the instruction register and instruction memory.
  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
// ---------------------------------------------------------------------------
// fetch_timeout_ctr - wait-cycle counter; expired flags the final allowed cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // High during the last permitted wait cycle, so the edge that ends it is edge TIMEOUT_CYC.
      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ins_fetch.sv
// ---------------------------------------------------------------------------
// ins_fetch - PC plus req/ack instruction-memory read feeding the IR bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int                DATA_W      = CPU_DATA_W,
  parameter int                ADDR_W      = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_req,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  output logic [DATA_W-1:0] ins_bus,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_busy,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [ADDR_W-1:0] pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic              im_req_q, im_req_d;
  logic [DATA_W-1:0] ins_bus_q, ins_bus_d;
  logic              ins_valid_q, ins_valid_d;
  logic              fetch_busy_q, fetch_busy_d;
  logic              fetch_err_q, fetch_err_d;

  logic fetch_start;
  logic to_clr;
  logic to_en;
  logic to_expired;

  assign fetch_start = (state_q == ST_IDLE) && fetch_req && !halt;
  assign to_clr      = (state_q != ST_WAIT);
  assign to_en       = (state_q == ST_WAIT) && !im_ack;

  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack is checked before expiry so a last-cycle ack still completes the fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (im_ack) begin
          state_d = ST_IDLE;
        end else if (to_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  if (pc_load) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    im_addr_d    = im_addr_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    im_req_d     = im_req_q;
    ins_bus_d    = ins_bus_q;
    ins_valid_d  = 1'b0;
    fetch_err_d  = fetch_err_q;
    fetch_busy_d = (state_d == ST_WAIT);
    case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          im_req_d  = 1'b1;
          im_addr_d = pc_load ? pc_load_val : pc_q;
          pc_d      = pc_load ? pc_load_val : pc_q;
        end else if (pc_load) begin
          pc_d = pc_load_val;
        end
      end
      ST_WAIT: begin
        if (im_ack) begin
          ins_bus_d   = im_data;
          ins_valid_d = 1'b1;
          im_req_d    = 1'b0;
          pend_d      = 1'b0;
          // A redirect arriving with the ack is the most recent one and wins.
          if (pc_load) begin
            pc_d = pc_load_val;
          end else if (pend_q) begin
            pc_d = pend_val_q;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end else begin
          if (pc_load) begin
            pend_d     = 1'b1;
            pend_val_d = pc_load_val;
          end
          if (to_expired) begin
            im_req_d    = 1'b0;
            fetch_err_d = 1'b1;
            pend_d      = 1'b0;
          end
        end
      end
      ST_ERR: begin
        im_req_d = 1'b0;
        if (pc_load) begin
          pc_d        = pc_load_val;
          fetch_err_d = 1'b0;
        end
      end
      default: begin
        im_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      im_addr_q    <= RESET_PC;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      im_req_q     <= 1'b0;
      ins_bus_q    <= '0;
      ins_valid_q  <= 1'b0;
      fetch_busy_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      im_addr_q    <= im_addr_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      im_req_q     <= im_req_d;
      ins_bus_q    <= ins_bus_d;
      ins_valid_q  <= ins_valid_d;
      fetch_busy_q <= fetch_busy_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign pc         = pc_q;
  assign im_addr    = im_addr_q;
  assign im_req     = im_req_q;
  assign ins_bus    = ins_bus_q;
  assign ins_valid  = ins_valid_q;
  assign fetch_busy = fetch_busy_q;
  assign fetch_err  = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ins_fetch.sv
// ---------------------------------------------------------------------------
// tb_ins_fetch - directed bench for ins_fetch with an ins_bus scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ins_fetch;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic              halt;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [ADDR_W-1:0] im_addr;
  logic              im_req;
  logic              im_ack;
  logic [DATA_W-1:0] im_data;
  logic [DATA_W-1:0] ins_bus;
  logic              ins_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_busy;
  logic              fetch_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_valid = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ins_fetch #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .RESET_PC    (8'h00),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .halt        (halt),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .im_addr     (im_addr),
    .im_req      (im_req),
    .im_ack      (im_ack),
    .im_data     (im_data),
    .ins_bus     (ins_bus),
    .ins_valid   (ins_valid),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every ins_valid pulse must match the next queued instruction.
  always @(negedge clk) begin
    if (ins_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ins_valid", {24'h0, ins_bus}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_ins_bus", {24'h0, ins_bus}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; fetch_req = 1'b0; halt = 1'b0; pc_load = 1'b0;
    pc_load_val = '0; im_ack = 1'b0; im_data = '0;
    step(); step();
    chk("rst_pc", {24'h0, pc}, 32'h00);
    chk("rst_im_addr", {24'h0, im_addr}, 32'h00);
    chk("rst_im_req", {31'h0, im_req}, 32'h0);
    chk("rst_ins_bus", {24'h0, ins_bus}, 32'h00);
    chk("rst_busy_err", {30'h0, fetch_busy, fetch_err}, 32'h0);

    // Idle for 10 cycles: nothing happens.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_im_req", {31'h0, im_req}, 32'h0);
    end
    chk("idle_pc", {24'h0, pc}, 32'h00);
    chk("idle_ins_bus", {24'h0, ins_bus}, 32'h00);
    chk("idle_no_valid", n_valid, 0);

    // Fetch at 0x00, ack after 3 cycles with 0xA5.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f1_im_addr", {24'h0, im_addr}, 32'h00);
    chk("f1_busy", {31'h0, fetch_busy}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (im_req) cnt++;
      if (i == 2) begin
        im_ack = 1'b1; im_data = 8'hA5; exp_q.push_back(8'hA5);
      end
      step();
    end
    im_ack = 1'b0;
    chk("f1_req_cycles", cnt, 3);
    chk("f1_im_req_low", {31'h0, im_req}, 32'h0);
    chk("f1_valid", {31'h0, ins_valid}, 32'h1);
    chk("f1_pc", {24'h0, pc}, 32'h01);
    step();
    chk("f1_valid_pulse", {31'h0, ins_valid}, 32'h0);
    chk("f1_bus_hold", {24'h0, ins_bus}, 32'hA5);

    // Jump to 0xFF, fetch with 1-cycle ack; PC wraps.
    pc_load = 1'b1; pc_load_val = 8'hFF;
    step();
    pc_load = 1'b0;
    chk("j_pc", {24'h0, pc}, 32'hFF);
    chk("j_no_req", {31'h0, im_req}, 32'h0);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f2_im_addr", {24'h0, im_addr}, 32'hFF);
    chk("f2_im_req", {31'h0, im_req}, 32'h1);
    im_ack = 1'b1; im_data = 8'h3C; exp_q.push_back(8'h3C);
    step();
    im_ack = 1'b0;
    chk("f2_ins_bus", {24'h0, ins_bus}, 32'h3C);
    chk("f2_pc_wrap", {24'h0, pc}, 32'h00);

    // Deferred redirect: two loads during WAIT, the later one wins.
    pc_load = 1'b1; pc_load_val = 8'h10;
    step();
    pc_load = 1'b0; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f3_im_addr", {24'h0, im_addr}, 32'h10);
    pc_load = 1'b1; pc_load_val = 8'h40;
    step();
    pc_load_val = 8'h50;
    step();
    pc_load = 1'b0;
    chk("f3_pc_in_wait", {24'h0, pc}, 32'h10);
    im_ack = 1'b1; im_data = 8'h77; exp_q.push_back(8'h77);
    step();
    im_ack = 1'b0;
    chk("f3_ins_bus", {24'h0, ins_bus}, 32'h77);
    chk("f3_pc_redirect", {24'h0, pc}, 32'h50);

    // Timeout: no ack, im_req held exactly 16 cycles.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    cnt = 0;
    while (im_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, 16);
    chk("to_err", {31'h0, fetch_err}, 32'h1);
    chk("to_busy", {31'h0, fetch_busy}, 32'h0);
    chk("to_bus_hold", {24'h0, ins_bus}, 32'h77);
    fetch_req = 1'b1; im_ack = 1'b1; im_data = 8'hEE;
    step(); step();
    fetch_req = 1'b0; im_ack = 1'b0;
    chk("err_no_req", {31'h0, im_req}, 32'h0);
    chk("err_bus_hold", {24'h0, ins_bus}, 32'h77);
    pc_load = 1'b1; pc_load_val = 8'h20;
    step();
    pc_load = 1'b0;
    chk("err_exit_err", {31'h0, fetch_err}, 32'h0);
    chk("err_exit_pc", {24'h0, pc}, 32'h20);

    // Ack in the very cycle the limit is hit: ack wins.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f4_im_addr", {24'h0, im_addr}, 32'h20);
    for (int i = 0; i < 15; i++) step();
    chk("f4_still_req", {31'h0, im_req}, 32'h1);
    im_ack = 1'b1; im_data = 8'h5A; exp_q.push_back(8'h5A);
    step();
    im_ack = 1'b0;
    chk("f4_no_err", {31'h0, fetch_err}, 32'h0);
    chk("f4_ins_bus", {24'h0, ins_bus}, 32'h5A);
    chk("f4_pc", {24'h0, pc}, 32'h21);

    // Reset mid-WAIT, then a stale ack is ignored.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f5_im_req", {31'h0, im_req}, 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_im_req", {31'h0, im_req}, 32'h0);
    chk("mr_pc", {24'h0, pc}, 32'h00);
    im_ack = 1'b1; im_data = 8'h99;
    step();
    im_ack = 1'b0;
    chk("mr_no_valid", {31'h0, ins_valid}, 32'h0);
    chk("mr_ins_bus", {24'h0, ins_bus}, 32'h00);
    chk("mr_im_req2", {31'h0, im_req}, 32'h0);

    step(); step();
    chk("sb_drained", exp_q.size(), 0);
    chk("valid_count", n_valid, 4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
